// File: rtl/common.sv
// Shared bus typedefs for the core's ibus/dbus ports and the single-beat cbus,
// plus the arbiter state encoding and request-conversion helpers.
package common;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  // Instruction fetches are always 32-bit reads.
  localparam logic [2:0] IBUS_SIZE = 3'b010;

  function automatic cbus_req_t ibus_to_cbus(input logic [63:0] addr);
    cbus_req_t c;
    c          = '0;
    c.valid    = 1'b1;
    c.size     = IBUS_SIZE;
    c.addr     = addr;
    return c;
  endfunction

  function automatic cbus_req_t dbus_to_cbus(input dbus_req_t r);
    cbus_req_t c;
    c.valid    = r.valid;
    c.is_write = (r.strobe != 8'h00);
    c.size     = r.size;
    c.addr     = r.addr;
    c.strobe   = r.strobe;
    c.data     = r.data;
    return c;
  endfunction

  function automatic logic [31:0] fetch_word(input logic [63:0] d, input logic hi);
    return hi ? d[63:32] : d[31:0];
  endfunction

endpackage

// File: rtl/core_bus_arbiter_if.sv
// Bundles the ibus/dbus request-response pairs and the shared cbus.
// master = the arbiter; slave = the core plus the memory system facing it.
interface core_bus_arbiter_if;
  import common::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  modport master (
    input  ireq,
    input  dreq,
    input  oresp,
    output iresp,
    output dresp,
    output oreq
  );

  modport slave (
    output ireq,
    output dreq,
    output oresp,
    input  iresp,
    input  dresp,
    input  oreq
  );

endinterface

// File: rtl/bus_resp_mux.sv
// Routes the captured cbus data to the owning requester, gated by that
// requester's live valid so flushed transactions return nothing.
module bus_resp_mux
  import common::*;
(
  input  logic        pulse,
  input  logic        owner_d,
  input  logic        hi_word,
  input  logic [63:0] cap_data,
  input  logic        ivalid,
  input  logic        dvalid,
  output ibus_resp_t  iresp,
  output dbus_resp_t  dresp
);

  always_comb begin
    iresp = '0;
    dresp = '0;
    if (pulse && !owner_d && ivalid) begin
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = fetch_word(cap_data, hi_word);
    end
    if (pulse && owner_d && dvalid) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = cap_data;
    end
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// Round-robin arbiter putting the core's ibus and dbus onto one single-beat
// cbus; oreq comes straight from a latch, responses pulse for one cycle.
module core_bus_arbiter
  import common::*;
#(
  parameter bit D_FIRST = 1'b1
) (
  input logic                clk,
  input logic                reset,
  core_bus_arbiter_if.master bus
);

  arb_state_t  state_reg, state_next;
  cbus_req_t   latch_reg, latch_next;
  logic [63:0] cap_data_reg;
  logic        owner_d_reg;
  logic        last_d_reg;
  logic        grant_i, grant_d, done, resp_pulse;

  // On a tie the requester not served last wins.
  assign grant_d = (state_reg == IDLE) && bus.dreq.valid
                   && (!bus.ireq.valid || !last_d_reg);
  assign grant_i = (state_reg == IDLE) && bus.ireq.valid && !grant_d;
  assign done    = ((state_reg == BUSY_I) || (state_reg == BUSY_D))
                   && bus.oresp.ready && bus.oresp.last;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_d)      state_next = BUSY_D;
        else if (grant_i) state_next = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (done) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    latch_next = latch_reg;
    if (grant_d)      latch_next = dbus_to_cbus(bus.dreq);
    else if (grant_i) latch_next = ibus_to_cbus(bus.ireq.addr);
    else if (done)    latch_next.valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      latch_reg    <= '0;
      cap_data_reg <= '0;
      owner_d_reg  <= 1'b0;
      last_d_reg   <= ~D_FIRST;
    end else begin
      latch_reg <= latch_next;
      if (done) begin
        cap_data_reg <= bus.oresp.data;
        owner_d_reg  <= (state_reg == BUSY_D);
        last_d_reg   <= (state_reg == BUSY_D);
      end
    end
  end

  always_comb begin
    bus.oreq   = latch_reg;
    resp_pulse = (state_reg == RESP);
  end

  // The latched address is kept through RESP to pick the fetch half-word.
  bus_resp_mux u_resp_mux (
    .pulse    (resp_pulse),
    .owner_d  (owner_d_reg),
    .hi_word  (latch_reg.addr[2]),
    .cap_data (cap_data_reg),
    .ivalid   (bus.ireq.valid),
    .dvalid   (bus.dreq.valid),
    .iresp    (bus.iresp),
    .dresp    (bus.dresp)
  );

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter: a cycle table plus hand-written
// flush and reset-mid-transaction sequences.
module tb_core_bus_arbiter;
  import common::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_bus_arbiter_if bus_if ();

  core_bus_arbiter #(.D_FIRST(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic rst; logic iv; logic [63:0] ia;
    logic dv; logic [63:0] da; logic [2:0] dsz; logic [7:0] dstb; logic [63:0] dd;
    logic rdy; logic lst; logic [63:0] rdata;
    logic ov; logic ow; logic [63:0] oa; logic [2:0] osz; logic [7:0] ostb; logic [63:0] od;
    logic iok; logic [31:0] idata; logic dok; logic chk_dd; logic [63:0] ddata;
  } vec_t;

  vec_t vecs[$];
  vec_t cur;

  localparam logic [63:0] IA   = 64'h8000_0004;
  localparam logic [63:0] IA2  = 64'h8000_0010;
  localparam logic [63:0] DA   = 64'h8000_0100;
  localparam logic [63:0] DA2  = 64'h8000_0200;
  localparam logic [63:0] DA3  = 64'h8000_0308;
  localparam logic [63:0] DD   = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] DD3  = 64'h5555_AAAA_0000_0000;
  localparam logic [63:0] RD1  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] RD2  = 64'hCAFE_F00D_0123_4567;
  localparam logic [63:0] RD3  = 64'h7777_8888_9999_AAAA;
  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic row_in(input logic rst, input logic iv, input logic [63:0] ia,
                        input logic dv, input logic [63:0] da, input logic [2:0] dsz,
                        input logic [7:0] dstb, input logic [63:0] dd,
                        input logic rdy, input logic lst, input logic [63:0] rdata);
    cur.rst = rst; cur.iv = iv; cur.ia = ia;
    cur.dv = dv; cur.da = da; cur.dsz = dsz; cur.dstb = dstb; cur.dd = dd;
    cur.rdy = rdy; cur.lst = lst; cur.rdata = rdata;
  endtask

  task automatic row_exp(input logic ov, input logic ow, input logic [63:0] oa,
                         input logic [2:0] osz, input logic [7:0] ostb, input logic [63:0] od,
                         input logic iok, input logic [31:0] idata,
                         input logic dok, input logic chk_dd, input logic [63:0] ddata);
    cur.ov = ov; cur.ow = ow; cur.oa = oa; cur.osz = osz; cur.ostb = ostb; cur.od = od;
    cur.iok = iok; cur.idata = idata; cur.dok = dok; cur.chk_dd = chk_dd; cur.ddata = ddata;
    vecs.push_back(cur);
  endtask

  task automatic drive(input vec_t v);
    reset              = v.rst;
    bus_if.ireq.valid  = v.iv;
    bus_if.ireq.addr   = v.ia;
    bus_if.dreq.valid  = v.dv;
    bus_if.dreq.addr   = v.da;
    bus_if.dreq.size   = v.dsz;
    bus_if.dreq.strobe = v.dstb;
    bus_if.dreq.data   = v.dd;
    bus_if.oresp.ready = v.rdy;
    bus_if.oresp.last  = v.lst;
    bus_if.oresp.data  = v.rdata;
  endtask

  task automatic idle_in();
    reset        = 1'b0;
    bus_if.ireq  = '0;
    bus_if.dreq  = '0;
    bus_if.oresp = '0;
  endtask

  task automatic set_oresp(input logic rdy, input logic lst, input logic [63:0] d);
    bus_if.oresp.ready = rdy;
    bus_if.oresp.last  = lst;
    bus_if.oresp.data  = d;
  endtask

  task automatic compare(input int k, input vec_t v);
    string t;
    t = $sformatf("v%0d", k);
    chk({t, "_ovalid"}, 64'(bus_if.oreq.valid), 64'(v.ov));
    if (v.ov) begin
      chk({t, "_is_write"}, 64'(bus_if.oreq.is_write), 64'(v.ow));
      chk({t, "_addr"}, bus_if.oreq.addr, v.oa);
      chk({t, "_size"}, 64'(bus_if.oreq.size), 64'(v.osz));
      chk({t, "_strobe"}, 64'(bus_if.oreq.strobe), 64'(v.ostb));
      chk({t, "_wdata"}, bus_if.oreq.data, v.od);
    end
    chk({t, "_i_data_ok"}, 64'(bus_if.iresp.data_ok), 64'(v.iok));
    chk({t, "_i_addr_ok"}, 64'(bus_if.iresp.addr_ok), 64'(v.iok));
    if (v.iok) begin
      chk({t, "_i_data"}, 64'(bus_if.iresp.data), 64'(v.idata));
      chk({t, "_d_nonowner_zero"}, {63'd0, bus_if.dresp != '0}, 64'd0);
    end
    chk({t, "_d_data_ok"}, 64'(bus_if.dresp.data_ok), 64'(v.dok));
    chk({t, "_d_addr_ok"}, 64'(bus_if.dresp.addr_ok), 64'(v.dok));
    if (v.dok) begin
      chk({t, "_i_nonowner_zero"}, {63'd0, bus_if.iresp != '0}, 64'd0);
      if (v.chk_dd) chk({t, "_d_data"}, bus_if.dresp.data, v.ddata);
    end
  endtask

  initial begin
    int n;
    idle_in();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_oreq_zero", {63'd0, bus_if.oreq != '0}, 64'd0);
    chk("reset_iresp_zero", {63'd0, bus_if.iresp != '0}, 64'd0);
    chk("reset_dresp_zero", {63'd0, bus_if.dresp != '0}, 64'd0);
    $display("[TB] reset state checked");

    // ibus read, odd word address: upper half returned
    row_in(0,1,IA, 0,0,0,0,0,  0,0,0);     row_exp(0,0,0,0,0,0, 0,0, 0,0,0);
    row_in(0,1,IA, 0,0,0,0,0,  1,1,RD1);   row_exp(1,0,IA,2,0,0, 0,0, 0,0,0);
    row_in(0,1,IA, 0,0,0,0,0,  0,0,0);     row_exp(0,0,0,0,0,0, 1,32'h1111_2222, 0,0,0);
    row_in(0,0,0,  0,0,0,0,0,  1,1,JUNK);  row_exp(0,0,0,0,0,0, 0,0, 0,0,0);
    // dbus store
    row_in(0,0,0, 1,DA,2,8'h0F,DD, 0,0,0); row_exp(0,0,0,0,0,0, 0,0, 0,0,0);
    row_in(0,0,0, 1,DA,2,8'h0F,DD, 1,1,0); row_exp(1,1,DA,2,8'h0F,DD, 0,0, 0,0,0);
    row_in(0,0,0, 1,DA,2,8'h0F,DD, 0,0,0); row_exp(0,0,0,0,0,0, 0,0, 1,0,0);
    row_in(0,0,0, 0,0,0,0,0,  1,1,JUNK);   row_exp(0,0,0,0,0,0, 0,0, 0,0,0);
    // reset clears round-robin history, then a tie goes to dbus
    row_in(1,0,0, 0,0,0,0,0,  0,0,0);      row_exp(0,0,0,0,0,0, 0,0, 0,0,0);
    row_in(0,1,IA, 1,DA2,3,0,0, 0,0,0);    row_exp(0,0,0,0,0,0, 0,0, 0,0,0);
    row_in(0,1,IA, 1,DA2,3,0,0, 1,1,RD2);  row_exp(1,0,DA2,3,0,0, 0,0, 0,0,0);
    row_in(0,1,IA, 1,DA2,3,0,0, 0,0,0);    row_exp(0,0,0,0,0,0, 0,0, 1,1,RD2);
    // second tie goes to ibus; ready without last holds the request
    row_in(0,1,IA, 1,DA3,3,8'hF0,DD3, 0,0,0);    row_exp(0,0,0,0,0,0, 0,0, 0,0,0);
    row_in(0,1,IA, 1,DA3,3,8'hF0,DD3, 1,0,JUNK); row_exp(1,0,IA,2,0,0, 0,0, 0,0,0);
    row_in(0,1,IA, 1,DA3,3,8'hF0,DD3, 1,0,JUNK); row_exp(1,0,IA,2,0,0, 0,0, 0,0,0);
    row_in(0,1,IA, 1,DA3,3,8'hF0,DD3, 1,1,RD3);  row_exp(1,0,IA,2,0,0, 0,0, 0,0,0);
    row_in(0,1,IA, 1,DA3,3,8'hF0,DD3, 0,0,0);    row_exp(0,0,0,0,0,0, 1,32'h7777_8888, 0,0,0);
    // next tie after ibus goes back to dbus
    row_in(0,1,IA2, 1,DA3,3,8'hF0,DD3, 0,0,0);   row_exp(0,0,0,0,0,0, 0,0, 0,0,0);
    row_in(0,1,IA2, 1,DA3,3,8'hF0,DD3, 1,1,0);   row_exp(1,1,DA3,3,8'hF0,DD3, 0,0, 0,0,0);
    row_in(0,1,IA2, 1,DA3,3,8'hF0,DD3, 0,0,0);   row_exp(0,0,0,0,0,0, 0,0, 1,0,0);
    row_in(0,1,IA2, 0,0,0,0,0, 0,0,0);           row_exp(0,0,0,0,0,0, 0,0, 0,0,0);
    row_in(0,1,IA2, 0,0,0,0,0, 1,1,RD1);         row_exp(1,0,IA2,2,0,0, 0,0, 0,0,0);
    row_in(0,1,IA2, 0,0,0,0,0, 0,0,0);           row_exp(0,0,0,0,0,0, 1,32'h3333_4444, 0,0,0);
    row_in(0,0,0,   0,0,0,0,0, 0,0,0);           row_exp(0,0,0,0,0,0, 0,0, 0,0,0);

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k]);
      #1;
      compare(k, vecs[k]);
      $display("[TB] vec %0d: ov=%0b iok=%0b dok=%0b", k, bus_if.oreq.valid,
               bus_if.iresp.data_ok, bus_if.dresp.data_ok);
    end

    // Flush: ibus drops valid while cbus stalls; no response, then regrant
    @(negedge clk);
    idle_in();
    bus_if.ireq.valid = 1'b1;
    bus_if.ireq.addr  = IA2;
    #1 chk("flush_idle_ov", 64'(bus_if.oreq.valid), 64'd0);
    @(negedge clk);
    bus_if.ireq.valid = 1'b0;
    #1 chk("flush_ov", 64'(bus_if.oreq.valid), 64'd1);
    chk("flush_addr", bus_if.oreq.addr, IA2);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      #1 chk("flush_stall_ov", 64'(bus_if.oreq.valid), 64'd1);
      chk("flush_stall_iok", 64'(bus_if.iresp.data_ok), 64'd0);
    end
    @(negedge clk);
    set_oresp(1'b1, 1'b1, RD1);
    #1 chk("flush_done_ov", 64'(bus_if.oreq.valid), 64'd1);
    @(negedge clk);
    set_oresp(1'b0, 1'b0, 64'd0);
    #1 chk("flush_gated_iok", 64'(bus_if.iresp.data_ok), 64'd0);
    chk("flush_gated_iaddr_ok", 64'(bus_if.iresp.addr_ok), 64'd0);
    chk("flush_dresp_zero", {63'd0, bus_if.dresp != '0}, 64'd0);
    chk("flush_resp_ov", 64'(bus_if.oreq.valid), 64'd0);
    $display("[TB] flush transaction completed");
    @(negedge clk);
    bus_if.ireq.valid = 1'b1;
    bus_if.ireq.addr  = IA;
    #1 chk("flush_back_idle", 64'(dut.state_reg), 64'(IDLE));
    n = 0;
    do begin
      @(negedge clk);
      #1 n++;
    end while (!bus_if.oreq.valid && n < 5);
    chk("regrant_ov", 64'(bus_if.oreq.valid), 64'd1);
    chk("regrant_addr", bus_if.oreq.addr, IA);
    set_oresp(1'b1, 1'b1, RD1);
    n = 0;
    do begin
      @(negedge clk);
      #1 n++;
    end while (!bus_if.iresp.data_ok && n < 5);
    chk("regrant_iok", 64'(bus_if.iresp.data_ok), 64'd1);
    chk("regrant_idata", 64'(bus_if.iresp.data), 64'h1111_2222);
    idle_in();
    $display("[TB] regrant after flush done");

    // Reset mid-transaction: first leave last_d=1 via a completed dbus read
    @(negedge clk);
    bus_if.dreq.valid = 1'b1;
    bus_if.dreq.addr  = DA2;
    bus_if.dreq.size  = 3'd3;
    n = 0;
    do begin
      @(negedge clk);
      #1 n++;
    end while (!bus_if.oreq.valid && n < 5);
    chk("rst_pre_ov", 64'(bus_if.oreq.valid), 64'd1);
    set_oresp(1'b1, 1'b1, RD2);
    n = 0;
    do begin
      @(negedge clk);
      #1 n++;
    end while (!bus_if.dresp.data_ok && n < 5);
    chk("rst_pre_dok", 64'(bus_if.dresp.data_ok), 64'd1);
    chk("rst_pre_ddata", bus_if.dresp.data, RD2);
    set_oresp(1'b0, 1'b0, 64'd0);
    @(negedge clk);
    bus_if.dreq.addr   = DA;
    bus_if.dreq.size   = 3'd2;
    bus_if.dreq.strobe = 8'h0F;
    bus_if.dreq.data   = DD;
    @(negedge clk);
    #1 chk("rst_busy_ov", 64'(bus_if.oreq.valid), 64'd1);
    chk("rst_busy_write", 64'(bus_if.oreq.is_write), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rst_stall_ov", 64'(bus_if.oreq.valid), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    bus_if.ireq.valid = 1'b1;
    bus_if.ireq.addr  = IA;
    #1 chk("rst_oreq_zero", {63'd0, bus_if.oreq != '0}, 64'd0);
    chk("rst_iresp_zero", {63'd0, bus_if.iresp != '0}, 64'd0);
    chk("rst_dresp_zero", {63'd0, bus_if.dresp != '0}, 64'd0);
    chk("rst_state_idle", 64'(dut.state_reg), 64'(IDLE));
    @(negedge clk);
    #1 chk("rst_tie_ov", 64'(bus_if.oreq.valid), 64'd1);
    chk("rst_tie_addr", bus_if.oreq.addr, DA);
    chk("rst_tie_write", 64'(bus_if.oreq.is_write), 64'd1);
    set_oresp(1'b1, 1'b1, 64'd0);
    @(negedge clk);
    #1 chk("rst_tie_dok", 64'(bus_if.dresp.data_ok), 64'd1);
    idle_in();
    $display("[TB] reset mid-transaction sequence done");
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
